// File: rtl/color_hist_locator_pkg.sv
// Shared definitions for the colour-histogram object locator: FSM state
// encoding, colour-filter codes and the column-to-LED mapping.
package color_hist_locator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        SCAN,
        PUBLISH
    } state_e;

    // Filter codes, bit2 red, bit1 green, bit0 blue.
    typedef enum logic [2:0] {
        FILT_NONE = 3'b000,
        FILT_B    = 3'b001,
        FILT_G    = 3'b010,
        FILT_GB   = 3'b011,
        FILT_R    = 3'b100,
        FILT_RB   = 3'b101,
        FILT_RG   = 3'b110,
        FILT_RGB  = 3'b111
    } filt_e;

    // Column 0 maps to the most significant LED.
    function automatic int led_index(input int col, input int n_leds, input int n_cols);
        return n_leds - 1 - (col * n_leds) / n_cols;
    endfunction

endpackage

// File: rtl/color_hist_locator_col_argmax.sv
// Running argmax over a stream of (value, index) pairs. start loads the
// first pair; later steps replace only on a strictly greater value, so the
// earliest index wins ties.
module col_argmax #(
    parameter int C_NB_VAL = 6,
    parameter int C_NB_IDX = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [C_NB_VAL-1:0] value,
    input  logic [C_NB_IDX-1:0] index,
    input  logic                start,
    input  logic                step,
    output logic [C_NB_VAL-1:0] max_val,
    output logic [C_NB_IDX-1:0] max_idx
);

    // Track the maximum seen since the last start.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (start) begin
            max_val <= value;
            max_idx <= index;
        end else if (step && (value > max_val)) begin
            max_val <= value;
            max_idx <= index;
        end
    end

endmodule

// File: rtl/color_hist_locator.sv
// Colour-histogram object locator. Streams one frame from the source
// buffer, writes the colour-filtered frame back out, builds a per-column
// count of matching pixels, then publishes the strongest column.
//
// state   | meaning
// IDLE    | waiting for en, histogram held clear
// STREAM  | issuing read addresses 0..N-1
// DRAIN   | last pixel of the frame arrives and is written
// SCAN    | argmax over the column histogram, one column per cycle
// PUBLISH | register results, pulse frame_done, clear histogram
module color_hist_locator
    import color_hist_locator_pkg::*;
#(
    parameter int C_IMG_COLS     = 80,
    parameter int C_IMG_ROWS     = 60,
    parameter int C_NB_IMG_PXLS  = 13,
    parameter int C_NB_BUF_RED   = 4,
    parameter int C_NB_BUF_GREEN = 4,
    parameter int C_NB_BUF_BLUE  = 4,
    parameter int C_NB_HIST      = 6,
    parameter int C_NB_LEDS      = 8,
    parameter int C_MIN_CNT      = 4,
    localparam int C_NB_BUF      = C_NB_BUF_RED + C_NB_BUF_GREEN + C_NB_BUF_BLUE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               rgbfilter,
    input  logic [C_NB_BUF-1:0]      orig_pxl,
    output logic [C_NB_IMG_PXLS-1:0] orig_addr,
    output logic                     proc_we,
    output logic [C_NB_BUF-1:0]      proc_pxl,
    output logic [C_NB_IMG_PXLS-1:0] proc_addr,
    output logic                     frame_done,
    output logic                     detected,
    output logic [7:0]               obj_col,
    output logic [C_NB_HIST-1:0]     obj_cnt,
    output logic [C_NB_LEDS-1:0]     leds
);

    localparam int N  = C_IMG_COLS * C_IMG_ROWS;
    localparam int CW = $clog2(C_IMG_COLS);
    localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(N - 1);
    localparam logic [CW-1:0]            LAST_COL  = CW'(C_IMG_COLS - 1);
    localparam logic [C_NB_HIST-1:0]     HIST_MAX  = '1;
    localparam logic [C_NB_HIST-1:0]     MIN_CNT   = C_NB_HIST'(C_MIN_CNT);

    state_e               state;
    logic [2:0]           filt_q;
    logic [CW-1:0]        orig_col;
    logic [CW-1:0]        proc_col;
    logic [CW-1:0]        scan_idx;
    logic [C_NB_HIST-1:0] hist [C_IMG_COLS];
    logic                 match;
    logic [C_NB_HIST-1:0] max_val;
    logic [CW-1:0]        max_idx;
    logic                 scan_start;
    logic                 scan_step;

    // Pixel passes when every selected colour has its MSB set.
    always_comb begin
        match = 1'b1;
        if (((filt_q & FILT_R) != 3'b000) && !orig_pxl[C_NB_BUF-1])
            match = 1'b0;
        if (((filt_q & FILT_G) != 3'b000) && !orig_pxl[C_NB_BUF_GREEN+C_NB_BUF_BLUE-1])
            match = 1'b0;
        if (((filt_q & FILT_B) != 3'b000) && !orig_pxl[C_NB_BUF_BLUE-1])
            match = 1'b0;
    end

    assign proc_pxl   = match ? orig_pxl : '0;
    assign scan_step  = (state == SCAN);
    assign scan_start = (state == SCAN) && (scan_idx == '0);

    col_argmax #(
        .C_NB_VAL (C_NB_HIST),
        .C_NB_IDX (CW)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .value   (hist[scan_idx]),
        .index   (scan_idx),
        .start   (scan_start),
        .step    (scan_step),
        .max_val (max_val),
        .max_idx (max_idx)
    );

    // Frame sequencer, write-back pipeline, histogram and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            filt_q     <= '0;
            orig_addr  <= '0;
            orig_col   <= '0;
            proc_we    <= 1'b0;
            proc_addr  <= '0;
            proc_col   <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
            detected   <= 1'b0;
            obj_col    <= '0;
            obj_cnt    <= '0;
            leds       <= '0;
            for (int i = 0; i < C_IMG_COLS; i++) hist[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            // Write side trails the read address by one cycle, matching
            // the source buffer's read latency.
            proc_we    <= (state == STREAM);
            proc_addr  <= orig_addr;
            proc_col   <= orig_col;

            if (proc_we && match && (hist[proc_col] != HIST_MAX))
                hist[proc_col] <= hist[proc_col] + 1'b1;

            case (state)
                IDLE: begin
                    orig_addr <= '0;
                    orig_col  <= '0;
                    for (int i = 0; i < C_IMG_COLS; i++) hist[i] <= '0;
                    if (en) begin
                        filt_q <= rgbfilter;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (orig_addr == LAST_ADDR) begin
                        orig_addr <= '0;
                        orig_col  <= '0;
                        state     <= DRAIN;
                    end else begin
                        orig_addr <= orig_addr + 1'b1;
                        orig_col  <= (orig_col == LAST_COL) ? '0 : orig_col + 1'b1;
                    end
                end
                DRAIN: begin
                    scan_idx <= '0;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (scan_idx == LAST_COL)
                        state <= PUBLISH;
                    else
                        scan_idx <= scan_idx + 1'b1;
                end
                PUBLISH: begin
                    obj_col    <= 8'(max_idx);
                    obj_cnt    <= max_val;
                    detected   <= (max_val >= MIN_CNT);
                    leds       <= (max_val >= MIN_CNT)
                                  ? (C_NB_LEDS'(1) << led_index(int'(max_idx), C_NB_LEDS, C_IMG_COLS))
                                  : '0;
                    frame_done <= 1'b1;
                    for (int i = 0; i < C_IMG_COLS; i++) hist[i] <= '0;
                    if (en) begin
                        filt_q <= rgbfilter;
                        state  <= STREAM;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_hist_locator.sv
// Directed bench for color_hist_locator at 80x60. A second instance with a
// 5-bit histogram shares the stimulus to exercise count saturation.
module tb_color_hist_locator;

    localparam int N = 4800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  rgbfilter = 3'b000;
    logic [11:0] mem [N];

    logic [11:0] pxl_a, pxl_b, ppxl_a, ppxl_b;
    logic [12:0] oaddr_a, oaddr_b, paddr_a, paddr_b;
    logic        we_a, we_b, done_a, done_b, det_a, det_b;
    logic [7:0]  col_a, col_b, leds_a, leds_b;
    logic [5:0]  cnt_a;
    logic [4:0]  cnt_b;

    int checks = 0;
    int failures = 0;
    int we_cnt, addr_err, pxl_err, first_addr, period;
    bit ok;

    always #5 clk = ~clk;

    // Source buffers with one-cycle read latency.
    always @(posedge clk) begin
        pxl_a <= mem[oaddr_a];
        pxl_b <= mem[oaddr_b];
    end

    color_hist_locator dut (
        .clk(clk), .rst(rst), .en(en), .rgbfilter(rgbfilter),
        .orig_pxl(pxl_a), .orig_addr(oaddr_a),
        .proc_we(we_a), .proc_pxl(ppxl_a), .proc_addr(paddr_a),
        .frame_done(done_a), .detected(det_a), .obj_col(col_a),
        .obj_cnt(cnt_a), .leds(leds_a)
    );

    color_hist_locator #(.C_NB_HIST(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .rgbfilter(rgbfilter),
        .orig_pxl(pxl_b), .orig_addr(oaddr_b),
        .proc_we(we_b), .proc_pxl(ppxl_b), .proc_addr(paddr_b),
        .frame_done(done_b), .detected(det_b), .obj_col(col_b),
        .obj_cnt(cnt_b), .leds(leds_b)
    );

    task automatic clear_img();
        for (int i = 0; i < N; i++) mem[i] = 12'h000;
    endtask

    task automatic set_col(input int col, input int rows, input logic [11:0] v);
        for (int r = 0; r < rows; r++) mem[r*80 + col] = v;
    endtask

    // Runs one frame while modelling the write-back stream; f is the filter
    // the frame is expected to use.
    task automatic run_frame(input logic [2:0] f, input bit drive_start, input bit keep_en,
                             input int chg_at, input logic [2:0] chg_f);
        int cyc;
        logic [12:0] exp_addr;
        logic [11:0] px, ep;
        logic m;
        cyc = 0; exp_addr = '0;
        we_cnt = 0; addr_err = 0; pxl_err = 0; ok = 0; first_addr = -1;
        if (drive_start) begin
            rgbfilter = f;
            en = 1'b1;
        end
        while (cyc < 6000 && !ok) begin
            @(negedge clk);
            cyc++;
            if (!keep_en) en = 1'b0;
            if (cyc == chg_at) rgbfilter = chg_f;
            if (cyc == 1) first_addr = int'(oaddr_a);
            if (we_a) begin
                we_cnt++;
                if (paddr_a !== exp_addr) addr_err++;
                exp_addr++;
                px = mem[paddr_a];
                m  = (!f[2] | px[11]) & (!f[1] | px[7]) & (!f[0] | px[3]);
                ep = m ? px : 12'h000;
                if (ppxl_a !== ep) pxl_err++;
            end
            if (done_a) ok = 1;
        end
        period = drive_start ? cyc - 1 : cyc;
    endtask

    task automatic test_reset();
        clear_img();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({we_a, oaddr_a, paddr_a, done_a, det_a, col_a, cnt_a, leds_a} !== '0) begin
            failures++;
            $display("FAIL reset_outputs we=%b oaddr=%0d paddr=%0d done=%b det=%b col=%0d cnt=%0d leds=%b expected all 0",
                     we_a, oaddr_a, paddr_a, done_a, det_a, col_a, cnt_a, leds_a);
        end
        checks++;
        if ({we_b, oaddr_b, done_b, det_b, col_b, cnt_b, leds_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_h5 cnt=%0d col=%0d leds=%b expected all 0", cnt_b, col_b, leds_b);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (we_a !== 1'b0 || oaddr_a !== 13'd0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold we=%b oaddr=%0d done=%b expected 0 0 0", we_a, oaddr_a, done_a);
        end
    endtask

    task automatic test_black();
        int extra;
        clear_img();
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || period !== 4882) begin
            failures++;
            $display("FAIL black_period got=%0d done_seen=%0d expected 4882", period, ok);
        end
        checks++;
        if (first_addr !== 0) begin
            failures++;
            $display("FAIL black_first_addr got=%0d expected 0", first_addr);
        end
        checks++;
        if (we_cnt !== 4800 || addr_err !== 0 || pxl_err !== 0) begin
            failures++;
            $display("FAIL black_stream writes=%0d addr_err=%0d pxl_err=%0d expected 4800 0 0", we_cnt, addr_err, pxl_err);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== '0) begin
            failures++;
            $display("FAIL black_result det=%b col=%0d cnt=%0d leds=%b expected 0 0 0 00000000", det_a, col_a, cnt_a, leds_a);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a || we_a || oaddr_a != 0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL black_back_to_idle activity_cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_red_col45();
        clear_img();
        set_col(45, 10, 12'hF00);
        set_col(20, 30, 12'h0F0);
        set_col(30, 40, 12'h700);
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || we_cnt !== 4800 || addr_err !== 0 || pxl_err !== 0) begin
            failures++;
            $display("FAIL red45_stream done=%0d writes=%0d addr_err=%0d pxl_err=%0d expected 1 4800 0 0", ok, we_cnt, addr_err, pxl_err);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd45, 6'd10, 8'b00001000}) begin
            failures++;
            $display("FAIL red45_result det=%b col=%0d cnt=%0d leds=%b expected 1 45 10 00001000", det_a, col_a, cnt_a, leds_a);
        end
        checks++;
        if (col_b !== 8'd45 || cnt_b !== 5'd10) begin
            failures++;
            $display("FAIL red45_h5 col=%0d cnt=%0d expected 45 10", col_b, cnt_b);
        end
    endtask

    task automatic test_threshold();
        clear_img();
        set_col(40, 3, 12'h800);
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || {det_a, col_a, cnt_a, leds_a} !== {1'b0, 8'd40, 6'd3, 8'b00000000}) begin
            failures++;
            $display("FAIL below_min det=%b col=%0d cnt=%0d leds=%b expected 0 40 3 00000000", det_a, col_a, cnt_a, leds_a);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (col_a !== 8'd40 || cnt_a !== 6'd3 || det_a !== 1'b0) begin
            failures++;
            $display("FAIL result_hold col=%0d cnt=%0d det=%b expected 40 3 0", col_a, cnt_a, det_a);
        end
        set_col(40, 4, 12'h800);
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || {det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd40, 6'd4, 8'b00001000}) begin
            failures++;
            $display("FAIL at_min det=%b col=%0d cnt=%0d leds=%b expected 1 40 4 00001000", det_a, col_a, cnt_a, leds_a);
        end
    endtask

    task automatic test_tie();
        clear_img();
        set_col(12, 10, 12'hF00);
        set_col(70, 10, 12'hF00);
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || {det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd12, 6'd10, 8'b01000000}) begin
            failures++;
            $display("FAIL tie_result det=%b col=%0d cnt=%0d leds=%b expected 1 12 10 01000000", det_a, col_a, cnt_a, leds_a);
        end
    endtask

    task automatic test_saturate();
        clear_img();
        set_col(33, 60, 12'h8AA);
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || {det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd33, 6'd60, 8'b00010000}) begin
            failures++;
            $display("FAIL full_col det=%b col=%0d cnt=%0d leds=%b expected 1 33 60 00010000", det_a, col_a, cnt_a, leds_a);
        end
        checks++;
        if (col_b !== 8'd33 || cnt_b !== 5'd31 || det_b !== 1'b1) begin
            failures++;
            $display("FAIL saturate_h5 col=%0d cnt=%0d det=%b expected 33 31 1", col_b, cnt_b, det_b);
        end
        // No filter: every pixel matches, all columns tie at 60.
        run_frame(3'b000, 1, 0, -1, 3'b000);
        checks++;
        if (!ok || we_cnt !== 4800 || pxl_err !== 0) begin
            failures++;
            $display("FAIL nofilt_stream done=%0d writes=%0d pxl_err=%0d expected 1 4800 0", ok, we_cnt, pxl_err);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd0, 6'd60, 8'b10000000}) begin
            failures++;
            $display("FAIL nofilt_result det=%b col=%0d cnt=%0d leds=%b expected 1 0 60 10000000", det_a, col_a, cnt_a, leds_a);
        end
        checks++;
        if (col_b !== 8'd0 || cnt_b !== 5'd31) begin
            failures++;
            $display("FAIL nofilt_h5 col=%0d cnt=%0d expected 0 31", col_b, cnt_b);
        end
    endtask

    task automatic test_back_to_back();
        clear_img();
        set_col(5, 20, 12'h800);
        set_col(60, 30, 12'h080);
        run_frame(3'b100, 1, 1, 2000, 3'b010);
        checks++;
        if (!ok || we_cnt !== 4800 || addr_err !== 0 || pxl_err !== 0) begin
            failures++;
            $display("FAIL chg_f1_stream done=%0d writes=%0d addr_err=%0d pxl_err=%0d expected 1 4800 0 0", ok, we_cnt, addr_err, pxl_err);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd5, 6'd20, 8'b10000000}) begin
            failures++;
            $display("FAIL chg_f1_result det=%b col=%0d cnt=%0d leds=%b expected 1 5 20 10000000", det_a, col_a, cnt_a, leds_a);
        end
        run_frame(3'b010, 0, 0, -1, 3'b000);
        checks++;
        if (!ok || period !== 4882) begin
            failures++;
            $display("FAIL b2b_period got=%0d done_seen=%0d expected 4882", period, ok);
        end
        checks++;
        if (we_cnt !== 4800 || addr_err !== 0 || pxl_err !== 0) begin
            failures++;
            $display("FAIL chg_f2_stream writes=%0d addr_err=%0d pxl_err=%0d expected 4800 0 0", we_cnt, addr_err, pxl_err);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd60, 6'd30, 8'b00000010}) begin
            failures++;
            $display("FAIL chg_f2_result det=%b col=%0d cnt=%0d leds=%b expected 1 60 30 00000010", det_a, col_a, cnt_a, leds_a);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hit;
        cyc = 0; hit = 0;
        rgbfilter = 3'b100;
        en = 1'b1;
        while (cyc < 3000 && !hit) begin
            @(negedge clk);
            cyc++;
            if (oaddr_a == 13'd2000) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_mid_reach addr=%0d expected 2000 within 3000 cycles", oaddr_a);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({we_a, oaddr_a, paddr_a, done_a, det_a, col_a, cnt_a, leds_a} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs we=%b oaddr=%0d paddr=%0d done=%b det=%b col=%0d cnt=%0d leds=%b expected all 0",
                     we_a, oaddr_a, paddr_a, done_a, det_a, col_a, cnt_a, leds_a);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame(3'b100, 1, 0, -1, 3'b000);
        checks++;
        if (first_addr !== 0 || !ok || period !== 4882) begin
            failures++;
            $display("FAIL rst_mid_restart first_addr=%0d period=%0d done_seen=%0d expected 0 4882 1", first_addr, period, ok);
        end
        checks++;
        if ({det_a, col_a, cnt_a, leds_a} !== {1'b1, 8'd5, 6'd20, 8'b10000000}) begin
            failures++;
            $display("FAIL rst_mid_result det=%b col=%0d cnt=%0d leds=%b expected 1 5 20 10000000", det_a, col_a, cnt_a, leds_a);
        end
    endtask

    initial begin
        test_reset();
        test_black();
        test_red_col45();
        test_threshold();
        test_tie();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/color_hist_locator.md
COLOR_HIST_LOCATOR -- requirements
Module: color_hist_locator

Interface
REQ-001 SHALL have parameter C_IMG_COLS, default 80, image width in pixels.
REQ-002 SHALL have parameter C_IMG_ROWS, default 60, image height in pixels.
REQ-003 SHALL have parameter C_NB_IMG_PXLS, default 13, pixel address width.
REQ-004 SHALL have parameters C_NB_BUF_RED, C_NB_BUF_GREEN and C_NB_BUF_BLUE, default 4 each, bits per colour; C_NB_BUF is their sum, packed red-green-blue from MSB down.
REQ-005 SHALL have parameter C_NB_HIST, default 6, width of each column counter.
REQ-006 SHALL have parameter C_NB_LEDS, default 8, LED count.
REQ-007 SHALL have parameter C_MIN_CNT, default 4, minimum column count for a detection.
REQ-008 SHALL have ports: clk in 1 (FPGA clock); rst in 1 (reset, synchronous, active-high).
REQ-009 SHALL have ports: en in 1 (run frames); rgbfilter in 3 (colour filter: bit2 red, bit1 green, bit0 blue).
REQ-010 SHALL have ports: orig_pxl in C_NB_BUF (pixel read); orig_addr out C_NB_IMG_PXLS (read address).
REQ-011 SHALL have ports: proc_we out 1; proc_pxl out C_NB_BUF; proc_addr out C_NB_IMG_PXLS (processed-pixel write).
REQ-012 SHALL have ports: frame_done out 1 (one-cycle pulse per frame); detected out 1; obj_col out 8 (winning column); obj_cnt out C_NB_HIST (winning count); leds out C_NB_LEDS.

Function
REQ-013 SHALL implement FSM states IDLE, STREAM, DRAIN, SCAN and PUBLISH.
REQ-014 SHALL move from IDLE to STREAM when en=1, latching rgbfilter into filt_q; filt_q is constant for the whole frame.
REQ-015 STREAM SHALL drive orig_addr=0..N-1 (N=C_IMG_COLS*C_IMG_ROWS) on consecutive cycles from a registered counter, then enter DRAIN for 1 cycle.
REQ-016 orig_pxl SHALL be the data for the orig_addr of the previous cycle; proc_addr SHALL equal that delayed address; proc_we SHALL be 1 exactly in the cycles where proc_addr holds valid data (the STREAM cycles after the first, plus DRAIN).
REQ-017 match SHALL be the AND of the MSBs of the colours selected in filt_q; filt_q=000 SHALL give match=1.
REQ-018 proc_pxl SHALL equal orig_pxl when match=1 and 0 otherwise; it is combinational from orig_pxl and filt_q.
REQ-019 A column index SHALL wrap 0..C_IMG_COLS-1 aligned with proc_addr; on proc_we with match=1, hist[col] SHALL increment and saturate at 2^C_NB_HIST-1.
REQ-020 SCAN SHALL last C_IMG_COLS cycles, reading hist[0..C_IMG_COLS-1] in order and tracking the maximum with a strict greater-than compare, so the lowest column wins ties.
REQ-021 PUBLISH SHALL last 1 cycle and SHALL perform all of the following in that cycle: register obj_col and obj_cnt; set detected = (max >= C_MIN_CNT); pulse frame_done; clear all hist entries; then go to STREAM if en=1, else IDLE.
REQ-022 leds SHALL update in PUBLISH: when detected=1, one-hot at index C_NB_LEDS-1-(obj_col*C_NB_LEDS/C_IMG_COLS), so column 0 lights the MSB LED; when detected=0, leds SHALL be all zero.
REQ-023 Results SHALL hold until the next PUBLISH.
REQ-024 Frame period SHALL be N+C_IMG_COLS+2 cycles.
REQ-025 en=0 mid-frame SHALL NOT abort the frame; the block completes to PUBLISH and then goes to IDLE.
REQ-026 A change on rgbfilter mid-frame SHALL take effect only at the next frame start.
REQ-027 In IDLE: proc_we=0, orig_addr=0 and hist cleared.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE and zero all counters, hist, proc_we, proc_addr, orig_addr, frame_done, detected, obj_col, obj_cnt, leds and filt_q, including mid-frame; the frame in progress is discarded and no frame_done is produced.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the filter code constants (000..111) and the LED-index helper function.
REQ-030 The argmax scan SHALL be a sub-module col_argmax (inputs value, index, start, step; outputs max_val, max_idx).

Verification (80x60, defaults)
REQ-031 All-black image, filter 100 -> proc_pxl all 0, detected=0, leds=00000000, frame_done after 4882 cycles.
REQ-032 Red (MSB red set) pixels in column 45, rows 0..9, filter 100 -> obj_col=45, obj_cnt=10, detected=1, leds=00001000.
REQ-033 Equal counts of 10 in columns 12 and 70 -> obj_col=12 (tie), leds=01000000.
REQ-034 Full red column, 60 rows (exceeds 63? no) plus C_NB_HIST=5 -> obj_cnt saturates at 31.
REQ-035 rgbfilter changed 100->010 mid-frame -> current frame results still red-based; next frame green-based.
REQ-036 rst asserted at pixel 2000 -> all outputs zero the next cycle, no frame_done; with en=1, the next frame restarts at orig_addr=0.
